// File: rtl/grf_multiport.sv
// grf_multiport -- general register file for the pipelined CPU.
//
// Provides NUM_RD combinational read ports and two write ports: W0 for the
// writeback stage and W1 for the long-latency MDU/load return. Both write
// ports forward to the read ports in the same cycle, and W0 wins a
// same-address collision. A per-register busy scoreboard feeds the stall
// logic. After reset an init sweep clears one register per cycle, and
// writes are accepted only once that sweep has finished.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   rd_addr / rd_data   packed read ports, port k at [k*ADDR_W] / [k*DATA_W]
//   rd_busy             per-port: register has a pending write not yet forwardable
//   we0/wa0/wd0         write port 0 (writeback)
//   we1/wa1/wd1         write port 1 (MDU/load return)
//   pc0, pc1            PC of the instruction on W0/W1 (trace only)
//   bs_set, bs_addr     mark bs_addr busy when a long-latency producer issues
//   ready               init sweep done; writes and bs_set are accepted
//
// Optional feature: define GRF_TRACE_EN to print one line per accepted write.
// The synthesised logic is the same with or without the macro.

module grf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [31:0]                pc0,
    input  logic [31:0]                pc1,
    input  logic                       bs_set,
    input  logic [ADDR_W-1:0]          bs_addr,
    output logic                       ready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;   // one extra bit so the terminal count cannot wrap
    logic [DATA_W-1:0]   regs_q [DEPTH];
    logic [DATA_W-1:0]   regs_d [DEPTH];
    logic [DEPTH-1:0]    busy_q, busy_d;

    logic run;
    assign run   = (state_q == S_RUN);
    assign ready = run;

    // Write-side qualifiers: register 0 is never written.
    logic w0_ok, w1_ok;
    assign w0_ok = we0 && (wa0 != '0);
    assign w1_ok = we1 && (wa1 != '0);

    // Next state: sweep, writes and scoreboard.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        busy_d  = busy_q;
        case (state_q)
            S_INIT: begin
                regs_d[cnt_q[ADDR_W-1:0]] = '0;
                busy_d[cnt_q[ADDR_W-1:0]] = 1'b0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (ADDR_W+1)'(DEPTH-1))
                    state_d = S_RUN;
            end
            S_RUN: begin
                // W1 first so that W0 overwrites it on a collision.
                if (w1_ok) begin
                    regs_d[wa1] = wd1;
                    busy_d[wa1] = 1'b0;
                end
                if (w0_ok) begin
                    regs_d[wa0] = wd0;
                    busy_d[wa0] = 1'b0;
                end
                // A new producer issued in the same cycle outranks the clear.
                if (bs_set)
                    busy_d[bs_addr] = 1'b1;
            end
            default: state_d = S_INIT;
        endcase
        busy_d[0] = 1'b0;
    end

    // The array and scoreboard are not bulk-reset; the sweep clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
            busy_q  <= busy_d;
        end
    end

    // Combinational read ports with write-port forwarding.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            logic hit0, hit1;
            a    = rd_addr[k*ADDR_W +: ADDR_W];
            hit0 = we0 && (wa0 == a);
            hit1 = we1 && (wa1 == a);
            if (run && (a != '0)) begin
                if (hit0)
                    rd_data[k*DATA_W +: DATA_W] = wd0;
                else if (hit1)
                    rd_data[k*DATA_W +: DATA_W] = wd1;
                else
                    rd_data[k*DATA_W +: DATA_W] = regs_q[a];
                // A write this cycle lifts the stall because its data is forwarded.
                rd_busy[k] = busy_q[a] && !hit0 && !hit1;
            end
        end
    end

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && run) begin
            if (w0_ok)
                $display("%d@%h: $%d <= %h", $time, pc0, wa0, wd0);
            if (w1_ok && !(we0 && (wa0 == wa1)))
                $display("%d@%h: $%d <= %h", $time, pc1, wa1, wd1);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{pc0, pc1};
`endif

endmodule

// File: tb/tb_grf_multiport.sv
// Directed bench for grf_multiport with the default parameters.
module tb_grf_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic              we0, we1, bs_set, ready;
    logic [AW-1:0]     wa0, wa1, bs_addr;
    logic [DW-1:0]     wd0, wd1;
    logic [31:0]       pc0, pc1;

    int n_assert = 0;
    int n_fail   = 0;

    grf_multiport #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
        .wa1(wa1), .wd1(wd1), .pc0(pc0), .pc1(pc1), .bs_set(bs_set),
        .bs_addr(bs_addr), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rdd(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ra(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    // Advance one clock edge, then settle inputs/outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_w();
        we0 = 0; we1 = 0; bs_set = 0;
    endtask

    initial begin
        reset = 1; rd_addr = '0; we0 = 0; we1 = 0; wa0 = '0; wa1 = '0;
        wd0 = '0; wd1 = '0; pc0 = 32'h100; pc1 = 32'h200; bs_set = 0; bs_addr = '0;
        tick(); tick();
        reset = 0;
        #1;
        // T1: sweep latency 32 cycles, reads 0 meanwhile
        chk("t1_ready_rst", {31'd0, ready}, 32'd0);
        set_ra(0, 5'd31);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 16) chk("t1_rd_init", rdd(0), 32'd0);
            if (i == 31) chk("t1_ready_31", {31'd0, ready}, 32'd0);
        end
        #1;
        chk("t1_ready_32", {31'd0, ready}, 32'd1);
        chk("t1_reg31_clr", rdd(0), 32'd0);

        // T2: W0 bypass then array read
        set_ra(0, 5'd5); we0 = 1; wa0 = 5'd5; wd0 = 32'h1234_5678; #1;
        chk("t2_bypass", rdd(0), 32'h1234_5678);
        tick(); idle_w(); #1;
        chk("t2_array", rdd(0), 32'h1234_5678);

        // T3: collision, W0 wins
        set_ra(0, 5'd7); we0 = 1; wa0 = 5'd7; wd0 = 32'hAAAA_0000;
        we1 = 1; wa1 = 5'd7; wd1 = 32'hBBBB_0000; #1;
        chk("t3_fwd", rdd(0), 32'hAAAA_0000);
        tick(); idle_w(); #1;
        chk("t3_array", rdd(0), 32'hAAAA_0000);

        // T4: scoreboard set then W1 clear with forwarding
        bs_set = 1; bs_addr = 5'd9; tick(); idle_w();
        set_ra(1, 5'd9); #1;
        chk("t4_busy", {31'd0, rd_busy[1]}, 32'd1);
        chk("t4_other_nb", {31'd0, rd_busy[0]}, 32'd0);
        we1 = 1; wa1 = 5'd9; wd1 = 32'h42; #1;
        chk("t4_fwd_busy", {31'd0, rd_busy[1]}, 32'd0);
        chk("t4_fwd_data", rdd(1), 32'h42);
        tick(); idle_w(); #1;
        chk("t4_busy_clr", {31'd0, rd_busy[1]}, 32'd0);
        chk("t4_array", rdd(1), 32'h42);

        // W1-only forward while W0 writes elsewhere
        set_ra(2, 5'd10); we0 = 1; wa0 = 5'd11; wd0 = 32'h1111;
        we1 = 1; wa1 = 5'd10; wd1 = 32'h1010; #1;
        chk("w1_fwd", rdd(2), 32'h1010);
        tick(); idle_w(); #1;
        chk("w1_array", rdd(2), 32'h1010);
        set_ra(2, 5'd11); #1;
        chk("w0_other", rdd(2), 32'h1111);

        // T5: set beats clear on same address
        bs_set = 1; bs_addr = 5'd3; we0 = 1; wa0 = 5'd3; wd0 = 32'hCAFE_0003;
        set_ra(2, 5'd3); #1;
        chk("t5_pre_busy", {31'd0, rd_busy[2]}, 32'd0);
        tick(); idle_w(); #1;
        chk("t5_busy", {31'd0, rd_busy[2]}, 32'd1);
        chk("t5_data", rdd(2), 32'hCAFE_0003);

        // T6: register 0 is immutable and never busy
        set_ra(0, 5'd0); we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; bs_set = 1; bs_addr = 5'd0; #1;
        chk("t6_fwd0", rdd(0), 32'd0);
        chk("t6_busy0", {31'd0, rd_busy[0]}, 32'd0);
        tick(); idle_w(); #1;
        chk("t6_reg0", rdd(0), 32'd0);
        chk("t6_busy0_after", {31'd0, rd_busy[0]}, 32'd0);

        // Reset during RUN: INIT outputs zero even for written registers
        reset = 1; tick(); reset = 0;
        set_ra(0, 5'd5); set_ra(2, 5'd3); #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_rd_zero", rdd(0), 32'd0);
        chk("rst_busy_zero", {31'd0, rd_busy[2]}, 32'd0);
        // sweep to cnt=10, then reset again
        for (int i = 1; i <= 10; i++) tick();
        reset = 1; tick(); reset = 0; #1;
        for (int i = 1; i <= 32; i++) begin
            // writes and bs_set during INIT must be ignored (cnt already past 5/6)
            if (i == 20) begin
                we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; bs_set = 1; bs_addr = 5'd6; #1;
                chk("init_no_fwd", rdd(0), 32'd0);
            end
            tick();
            if (i == 20) idle_w();
            if (i == 31) chk("sweep2_ready_31", {31'd0, ready}, 32'd0);
        end
        #1;
        chk("sweep2_ready_32", {31'd0, ready}, 32'd1);
        chk("sweep2_reg5", rdd(0), 32'd0);
        chk("sweep2_busy3", {31'd0, rd_busy[2]}, 32'd0);
        set_ra(1, 5'd6); #1;
        chk("sweep2_busy6", {31'd0, rd_busy[1]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
